// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control sequencer.
// State codes are fixed because they are driven straight out on the state port.
package stopwatch_pkg;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_PAUSE = 2'b10;
   localparam logic [1:0] ST_LAP   = 2'b11;

endpackage : stopwatch_pkg

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-flop synchroniser, stable-count debounce,
// and a one-cycle pulse on each debounced press (release is silent).
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw_i,
   output logic press_o
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lvl_q, lvl_d;
   logic          press_q, press_d;

   // The level flips on the cycle after the count has sat at DEBOUNCE_CYCLES,
   // so the press pulse lands 2 + DEBOUNCE_CYCLES + 1 cycles after the raw edge.
   always_comb begin
      cnt_d   = '0;
      lvl_d   = lvl_q;
      press_d = 1'b0;
      if (sync_q[1] != lvl_q) begin
         if (cnt_q == CNT_LAST) begin
            lvl_d   = sync_q[1];
            press_d = sync_q[1];
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         lvl_q   <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn_raw_i};
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule : btn_debounce

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounced start/stop and lap/reset buttons drive an
// idle/run/pause/lap FSM, a tick prescaler and the timer control strobes.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned TICK_DIV        = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_ss_raw,
   input  logic       btn_lr_raw,
   input  logic       cnt_max,
   output logic       cnt_en,
   output logic       cnt_clr,
   output logic       disp_hold,
   output logic       ovf,
   output logic [1:0] state
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

   logic          ss_p, lr_p;
   logic [1:0]    state_q, state_d;
   logic [PW-1:0] ps_q, ps_d;
   logic          ovf_q, ovf_d;
   logic          counting, tick, ovf_tick;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw_i (btn_ss_raw),
      .press_o   (ss_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lr (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw_i (btn_lr_raw),
      .press_o   (lr_p)
   );

   assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
   assign tick     = counting && (ps_q == PS_LAST);
   assign ovf_tick = tick && cnt_max;

   // Priority per state: overflow tick, then start/stop, then lap/reset.
   always_comb begin
      state_d = state_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (ss_p) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (ovf_tick) begin
               state_d = ST_PAUSE;
               ovf_d   = 1'b1;
            end else if (ss_p) state_d = ST_PAUSE;
            else if (lr_p)     state_d = ST_LAP;
         end
         ST_LAP: begin
            if (ovf_tick) begin
               state_d = ST_PAUSE;
               ovf_d   = 1'b1;
            end else if (ss_p) state_d = ST_PAUSE;
            else if (lr_p)     state_d = ST_RUN;
         end
         default: begin
            if (ss_p && !ovf_q) state_d = ST_RUN;
            else if (lr_p) begin
               state_d = ST_IDLE;
               ovf_d   = 1'b0;
            end
         end
      endcase
   end

   // Pause holds the prescaler so a resume keeps its sub-tick phase.
   always_comb begin
      ps_d = ps_q;
      if (state_q == ST_IDLE)  ps_d = '0;
      else if (counting)       ps_d = (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ps_q    <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ps_q    <= ps_d;
         ovf_q   <= ovf_d;
      end
   end

   assign cnt_en    = tick && !cnt_max;
   assign cnt_clr   = (state_q == ST_IDLE);
   assign disp_hold = (state_q == ST_LAP);
   assign ovf       = ovf_q;
   assign state     = state_q;

endmodule : stopwatch_ctrl

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=5.
// Expected values are hand-derived; inputs change and outputs are sampled 1ns after posedge.
module tb_stopwatch_ctrl;

   logic       clk;
   logic       rst_n;
   logic       btn_ss_raw;
   logic       btn_lr_raw;
   logic       cnt_max;
   logic       cnt_en;
   logic       cnt_clr;
   logic       disp_hold;
   logic       ovf;
   logic [1:0] state;

   int checks   = 0;
   int failures = 0;
   int ss_cnt   = 0;
   int en_cnt   = 0;
   int en_snap;

   stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_DIV(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_ss_raw (btn_ss_raw),
      .btn_lr_raw (btn_lr_raw),
      .cnt_max    (cnt_max),
      .cnt_en     (cnt_en),
      .cnt_clr    (cnt_clr),
      .disp_hold  (disp_hold),
      .ovf        (ovf),
      .state      (state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Completed pulses are counted at the falling edge of the cycle they occupy.
   always @(negedge clk) begin
      if (dut.ss_p) ss_cnt++;
      if (cnt_en)   en_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Hold the given buttons long enough for one debounced press; the FSM has
   // reacted by the time this returns.
   task automatic press(input logic ss, input logic lr);
      btn_ss_raw = ss;
      btn_lr_raw = lr;
      step(8);
      btn_ss_raw = 1'b0;
      btn_lr_raw = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      btn_ss_raw = 1'b0;
      btn_lr_raw = 1'b0;
      cnt_max    = 1'b0;
      step(3);
      check("rst_state", state, 2'b00);
      check("rst_cnt_en", cnt_en, 1'b0);
      check("rst_cnt_clr", cnt_clr, 1'b1);
      check("rst_disp_hold", disp_hold, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      rst_n = 1'b1;
      step(1);

      // 1: start press latency and tick cadence
      btn_ss_raw = 1'b1;
      step(6);
      check("ss_p_early", dut.ss_p, 1'b0);
      step(1);
      check("ss_p_at_7", dut.ss_p, 1'b1);
      check("state_before_edge", state, 2'b00);
      step(1);
      check("ss_p_one_cycle", dut.ss_p, 1'b0);
      check("state_run", state, 2'b01);
      check("cnt_clr_run", cnt_clr, 1'b0);
      step(2);
      btn_ss_raw = 1'b0;
      step(1);
      check("no_tick_ps3", cnt_en, 1'b0);
      step(1);
      check("tick1", cnt_en, 1'b1);
      step(1);
      check("tick1_end", cnt_en, 1'b0);
      step(4);
      check("tick2", cnt_en, 1'b1);
      step(1);

      // 2: short glitch is filtered
      btn_ss_raw = 1'b1;
      step(3);
      btn_ss_raw = 1'b0;
      step(1);
      check("glitch_tick", cnt_en, 1'b1);
      check("glitch_state", state, 2'b01);
      step(1);
      check("en_cnt_t2", en_cnt, 3);

      // 3: lap view, return, pause, resume phase
      press(1'b0, 1'b1);
      check("lap_state", state, 2'b11);
      check("lap_hold", disp_hold, 1'b1);
      step(8);
      check("lap_cnt_en", en_cnt, 6);
      check("ss_single_pulse", ss_cnt, 1);
      press(1'b0, 1'b1);
      check("lap_back_state", state, 2'b01);
      check("lap_back_hold", disp_hold, 1'b0);
      check("lap_back_tick", cnt_en, 1'b1);
      step(9);
      check("run_en_cnt", en_cnt, 9);
      press(1'b1, 1'b0);
      check("pause_state", state, 2'b10);
      check("pause_cnt_en", cnt_en, 1'b0);
      check("pause_en_cnt", en_cnt, 11);
      step(8);
      check("pause_no_en", en_cnt, 11);
      press(1'b1, 1'b0);
      check("resume_state", state, 2'b01);
      step(2);
      check("resume_ps3", cnt_en, 1'b0);
      step(1);
      check("resume_phase", cnt_en, 1'b1);
      step(8);

      // 4: simultaneous presses in pause
      press(1'b1, 1'b0);
      check("pause2_state", state, 2'b10);
      step(8);
      press(1'b1, 1'b1);
      check("both_ss_wins", state, 2'b01);
      check("both_cnt_clr", cnt_clr, 1'b0);
      step(1);
      check("both_lr_dropped", state, 2'b01);
      step(9);

      // 5: overflow saturation and sticky flag
      cnt_max = 1'b1;
      step(3);
      check("ovf_pre_state", state, 2'b01);
      step(1);
      check("ovf_tick_no_en", cnt_en, 1'b0);
      check("ovf_pre_flag", ovf, 1'b0);
      step(1);
      check("ovf_state", state, 2'b10);
      check("ovf_set", ovf, 1'b1);
      step(8);
      press(1'b1, 1'b0);
      check("ovf_ss_ignored", state, 2'b10);
      check("ovf_still_set", ovf, 1'b1);
      step(8);
      press(1'b0, 1'b1);
      check("ovf_exit_state", state, 2'b00);
      check("ovf_cleared", ovf, 1'b0);
      check("ovf_exit_clr", cnt_clr, 1'b1);
      step(8);
      cnt_max = 1'b0;

      // 6: asynchronous reset mid-run
      press(1'b1, 1'b0);
      check("t6_run", state, 2'b01);
      step(3);
      check("t6_ps3", cnt_en, 1'b0);
      en_snap = en_cnt;
      #2 rst_n = 1'b0;
      #1;
      check("async_state", state, 2'b00);
      check("async_cnt_en", cnt_en, 1'b0);
      check("async_cnt_clr", cnt_clr, 1'b1);
      step(3);
      check("rst_hold_no_en", en_cnt, en_snap);
      rst_n = 1'b1;
      step(2);
      press(1'b1, 1'b0);
      check("post_rst_run", state, 2'b01);
      step(3);
      check("post_rst_ps3", cnt_en, 1'b0);
      step(1);
      check("post_rst_phase", cnt_en, 1'b1);
      step(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_stopwatch_ctrl
